// File: rtl/pipe_pkg.sv
// Shared types and defaults for the inter-stage pipeline register (pipe_stage_reg / pipe_entry).
// PIPE_STAGE_SKID_EN (see pipe_stage_reg) enables the PIPE_SKID state.
package pipe_pkg;

    localparam int PIPE_NB_DATA = 32;
    localparam int PIPE_NB_CTRL = 16;

    // An all-zero control bundle is a bubble: NOP opcode, no register/memory writes, no branch.
    localparam logic [PIPE_NB_CTRL-1:0] PIPE_CTRL_NOP = '0;

    typedef enum logic [1:0] {
        PIPE_EMPTY = 2'd0,
        PIPE_FULL  = 2'd1,
        PIPE_SKID  = 2'd2
    } pipe_state_e;

endpackage

// File: rtl/pipe_entry.sv
// Step-gated ctrl+data holding register. Load wins over clear; clear only bubbles ctrl,
// data is left as-is because it is a don't-care once the entry is invalid.
module pipe_entry
    import pipe_pkg::*;
#(
    parameter int NB_CTRL = PIPE_NB_CTRL,
    parameter int NB_BUS  = 3 * PIPE_NB_DATA
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic               i_step,
    input  logic               i_load,
    input  logic               i_clear,
    input  logic [NB_CTRL-1:0] i_ctrl,
    input  logic [NB_BUS-1:0]  i_data,
    output logic [NB_CTRL-1:0] o_ctrl,
    output logic [NB_BUS-1:0]  o_data
);

    logic [NB_CTRL-1:0] ctrl_q;
    logic [NB_BUS-1:0]  data_q;

    always_ff @(negedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            ctrl_q <= NB_CTRL'(PIPE_CTRL_NOP);
            data_q <= '0;
        end else if (i_step) begin
            if (i_load) begin
                ctrl_q <= i_ctrl;
                data_q <= i_data;
            end else if (i_clear) begin
                ctrl_q <= NB_CTRL'(PIPE_CTRL_NOP);
            end
        end
    end

    assign o_ctrl = ctrl_q;
    assign o_data = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready, flush-to-bubble and debug step gating.
// Define PIPE_STAGE_SKID_EN to add a skid entry so o_ready no longer depends on i_ready.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int NB_DATA = PIPE_NB_DATA,
    parameter int N_DATA  = 3,
    parameter int NB_CTRL = PIPE_NB_CTRL,
    parameter int NB_CNT  = 16
) (
    input  logic                      i_clk,
    input  logic                      i_reset_n,
    input  logic                      i_step,
    input  logic                      i_flush,
    input  logic                      i_valid,
    output logic                      o_ready,
    input  logic [NB_CTRL-1:0]        i_ctrl,
    input  logic [N_DATA*NB_DATA-1:0] i_data,
    output logic                      o_valid,
    input  logic                      i_ready,
    output logic [NB_CTRL-1:0]        o_ctrl,
    output logic [N_DATA*NB_DATA-1:0] o_data,
    output logic [NB_CNT-1:0]         o_stall_count
);

    localparam int NB_BUS = N_DATA * NB_DATA;

    pipe_state_e        state_q, state_d;
    logic               push, pop, flush;
    logic               main_load, main_clear;
    logic [NB_CTRL-1:0] main_ctrl_in, main_ctrl;
    logic [NB_BUS-1:0]  main_data_in;
    logic [NB_CNT-1:0]  stall_cnt_q, stall_cnt_d;

    assign o_valid = (state_q != PIPE_EMPTY);
    assign flush   = i_flush & i_step;
    assign push    = i_valid & o_ready & i_step;
    assign pop     = o_valid & i_ready & i_step;

`ifdef PIPE_STAGE_SKID_EN
    logic               skid_load, skid_clear;
    logic [NB_CTRL-1:0] skid_ctrl;
    logic [NB_BUS-1:0]  skid_data;

    assign o_ready = (state_q != PIPE_SKID);

    always_comb begin
        state_d      = state_q;
        main_load    = 1'b0;
        main_clear   = 1'b0;
        skid_load    = 1'b0;
        skid_clear   = 1'b0;
        main_ctrl_in = i_ctrl;
        main_data_in = i_data;
        if (flush) begin
            state_d    = PIPE_EMPTY;
            main_clear = 1'b1;
            skid_clear = 1'b1;
        end else begin
            case (state_q)
                PIPE_EMPTY: begin
                    if (push) begin
                        state_d   = PIPE_FULL;
                        main_load = 1'b1;
                    end
                end
                PIPE_FULL: begin
                    if (push && pop) begin
                        main_load = 1'b1;
                    end else if (push) begin
                        state_d   = PIPE_SKID;
                        skid_load = 1'b1;
                    end else if (pop) begin
                        state_d    = PIPE_EMPTY;
                        main_clear = 1'b1;
                    end
                end
                PIPE_SKID: begin
                    // The older entry leaves; the skid entry moves up to preserve order.
                    if (pop) begin
                        state_d      = PIPE_FULL;
                        main_load    = 1'b1;
                        main_ctrl_in = skid_ctrl;
                        main_data_in = skid_data;
                        skid_clear   = 1'b1;
                    end
                end
                default: state_d = PIPE_EMPTY;
            endcase
        end
    end

    pipe_entry #(
        .NB_CTRL (NB_CTRL),
        .NB_BUS  (NB_BUS)
    ) u_skid (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_step    (i_step),
        .i_load    (skid_load),
        .i_clear   (skid_clear),
        .i_ctrl    (i_ctrl),
        .i_data    (i_data),
        .o_ctrl    (skid_ctrl),
        .o_data    (skid_data)
    );
`else
    assign o_ready      = ~o_valid | i_ready;
    assign main_ctrl_in = i_ctrl;
    assign main_data_in = i_data;

    always_comb begin
        state_d    = state_q;
        main_load  = 1'b0;
        main_clear = 1'b0;
        if (flush) begin
            state_d    = PIPE_EMPTY;
            main_clear = 1'b1;
        end else if (push) begin
            state_d   = PIPE_FULL;
            main_load = 1'b1;
        end else if (pop) begin
            state_d    = PIPE_EMPTY;
            main_clear = 1'b1;
        end
    end
`endif

    pipe_entry #(
        .NB_CTRL (NB_CTRL),
        .NB_BUS  (NB_BUS)
    ) u_main (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_step    (i_step),
        .i_load    (main_load),
        .i_clear   (main_clear),
        .i_ctrl    (main_ctrl_in),
        .i_data    (main_data_in),
        .o_ctrl    (main_ctrl),
        .o_data    (o_data)
    );

    assign stall_cnt_d = (i_step && o_valid && !i_ready && (stall_cnt_q != '1))
                       ? stall_cnt_q + NB_CNT'(1) : stall_cnt_q;

    always_ff @(negedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q     <= PIPE_EMPTY;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign o_ctrl        = o_valid ? main_ctrl : NB_CTRL'(PIPE_CTRL_NOP);
    assign o_stall_count = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg (NB_CNT=4); expectations follow PIPE_STAGE_SKID_EN when defined.
module tb_pipe_stage_reg;

    localparam int NB_DATA = 32;
    localparam int N_DATA  = 3;
    localparam int NB_CTRL = 16;
    localparam int NB_CNT  = 4;
    localparam int NB_BUS  = N_DATA * NB_DATA;

    logic               i_clk = 1'b1;
    logic               i_reset_n;
    logic               i_step;
    logic               i_flush;
    logic               i_valid;
    logic               o_ready;
    logic [NB_CTRL-1:0] i_ctrl;
    logic [NB_BUS-1:0]  i_data;
    logic               o_valid;
    logic               i_ready;
    logic [NB_CTRL-1:0] o_ctrl;
    logic [NB_BUS-1:0]  o_data;
    logic [NB_CNT-1:0]  o_stall_count;

    int total = 0;
    int bad   = 0;

    pipe_stage_reg #(
        .NB_DATA (NB_DATA),
        .N_DATA  (N_DATA),
        .NB_CTRL (NB_CTRL),
        .NB_CNT  (NB_CNT)
    ) dut (
        .i_clk         (i_clk),
        .i_reset_n     (i_reset_n),
        .i_step        (i_step),
        .i_flush       (i_flush),
        .i_valid       (i_valid),
        .o_ready       (o_ready),
        .i_ctrl        (i_ctrl),
        .i_data        (i_data),
        .o_valid       (o_valid),
        .i_ready       (i_ready),
        .o_ctrl        (o_ctrl),
        .o_data        (o_data),
        .o_stall_count (o_stall_count)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [NB_BUS-1:0] mkdata(input logic [15:0] c);
        return {16'hDA02, c, 16'hDA01, c, 16'hDA00, c};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Active edge is the falling edge; outputs are sampled 1 time unit after it.
    task automatic tick();
        @(negedge i_clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] c);
        i_valid = v;
        i_ctrl  = c;
        i_data  = mkdata(c);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        i_reset_n = 1'b0;
        i_step    = 1'b1;
        i_flush   = 1'b0;
        i_ready   = 1'b1;
        drive(1'b0, 16'h0000);
        #1;
        chk("rst_valid", 128'(o_valid), 128'(0));
        chk("rst_ctrl",  128'(o_ctrl),  128'(0));
        chk("rst_data",  128'(o_data),  128'(0));
        chk("rst_ready", 128'(o_ready), 128'(1));
        chk("rst_cnt",   128'(o_stall_count), 128'(0));
        #7 i_reset_n = 1'b1;

        // Free-running stream: each word shows up right after the edge that pushed it.
        for (int c = 1; c <= 8; c++) begin
            drive(1'b1, 16'(c));
            tick();
            $display("stream push ctrl=%0h -> o_ctrl=%0h o_valid=%0b", c, o_ctrl, o_valid);
            chk("stream_valid", 128'(o_valid), 128'(1));
            chk("stream_ctrl",  128'(o_ctrl),  128'(c));
            chk("stream_data",  128'(o_data),  128'(mkdata(16'(c))));
        end
        drive(1'b0, 16'h0000);
        tick();
        chk("drain_valid", 128'(o_valid), 128'(0));
        chk("drain_ctrl",  128'(o_ctrl),  128'(0));
        chk("drain_cnt",   128'(o_stall_count), 128'(0));

        // Back-pressure: A enters an empty stage, then three stalled edges.
        i_ready = 1'b0;
        drive(1'b1, 16'h00A1);
        tick();
        $display("bp push A -> o_ctrl=%0h o_ready=%0b", o_ctrl, o_ready);
        chk("bp_a_ctrl", 128'(o_ctrl), 128'(16'h00A1));
`ifdef PIPE_STAGE_SKID_EN
        chk("bp_a_ready", 128'(o_ready), 128'(1));
        drive(1'b1, 16'h00B2);
        tick();
        chk("bp_b_ready", 128'(o_ready), 128'(0));
        drive(1'b0, 16'h0000);
        tick();
        tick();
        $display("bp stalled -> o_ctrl=%0h o_ready=%0b cnt=%0d", o_ctrl, o_ready, o_stall_count);
        chk("bp_hold_ctrl", 128'(o_ctrl), 128'(16'h00A1));
        chk("bp_cnt", 128'(o_stall_count), 128'(3));
        i_ready = 1'b1;
        #1;
        chk("bp_ready_registered", 128'(o_ready), 128'(0));
        tick();
        $display("bp release -> o_ctrl=%0h", o_ctrl);
        chk("bp_deliver_b", 128'(o_ctrl), 128'(16'h00B2));
        chk("bp_deliver_b_data", 128'(o_data), 128'(mkdata(16'h00B2)));
        chk("bp_after_ready", 128'(o_ready), 128'(1));
`else
        chk("bp_a_ready", 128'(o_ready), 128'(0));
        drive(1'b1, 16'h00B2);
        tick();
        tick();
        tick();
        $display("bp stalled -> o_ctrl=%0h o_ready=%0b cnt=%0d", o_ctrl, o_ready, o_stall_count);
        chk("bp_hold_ctrl", 128'(o_ctrl), 128'(16'h00A1));
        chk("bp_cnt", 128'(o_stall_count), 128'(3));
        i_ready = 1'b1;
        #1;
        chk("bp_ready_comb", 128'(o_ready), 128'(1));
        tick();
        $display("bp release -> o_ctrl=%0h", o_ctrl);
        chk("bp_deliver_b", 128'(o_ctrl), 128'(16'h00B2));
        chk("bp_deliver_b_data", 128'(o_data), 128'(mkdata(16'h00B2)));
        drive(1'b0, 16'h0000);
`endif
        tick();
        chk("bp_empty", 128'(o_valid), 128'(0));
        chk("bp_cnt_hold", 128'(o_stall_count), 128'(3));

        // Flush with a simultaneous push of C: C must never appear.
        i_ready = 1'b0;
        drive(1'b1, 16'h00A1);
        tick();
`ifdef PIPE_STAGE_SKID_EN
        drive(1'b1, 16'h00B2);
        tick();
        chk("fl_skid_ready", 128'(o_ready), 128'(0));
`else
        i_ready = 1'b1;
`endif
        i_flush = 1'b1;
        drive(1'b1, 16'h00C3);
        tick();
        $display("flush -> o_valid=%0b o_ctrl=%0h o_ready=%0b", o_valid, o_ctrl, o_ready);
        chk("fl_valid", 128'(o_valid), 128'(0));
        chk("fl_ctrl",  128'(o_ctrl),  128'(0));
        chk("fl_ready", 128'(o_ready), 128'(1));
        i_flush = 1'b0;
        i_ready = 1'b1;
        drive(1'b0, 16'h0000);
        tick();
        chk("fl_no_c", 128'(o_valid), 128'(0));
`ifdef PIPE_STAGE_SKID_EN
        chk("fl_cnt", 128'(o_stall_count), 128'(5));
`else
        chk("fl_cnt", 128'(o_stall_count), 128'(3));
`endif

        // Step gating: hold D, then 5 gated edges with push, flush and stall requested.
        i_ready = 1'b0;
        drive(1'b1, 16'h00D4);
        tick();
        chk("sg_load_d", 128'(o_ctrl), 128'(16'h00D4));
        i_step  = 1'b0;
        i_flush = 1'b1;
        drive(1'b1, 16'h00E5);
        for (int k = 0; k < 5; k++) tick();
        $display("step gated -> o_ctrl=%0h o_valid=%0b cnt=%0d", o_ctrl, o_valid, o_stall_count);
        chk("sg_valid", 128'(o_valid), 128'(1));
        chk("sg_ctrl",  128'(o_ctrl),  128'(16'h00D4));
        chk("sg_data",  128'(o_data),  128'(mkdata(16'h00D4)));
`ifdef PIPE_STAGE_SKID_EN
        chk("sg_cnt", 128'(o_stall_count), 128'(5));
`else
        chk("sg_cnt", 128'(o_stall_count), 128'(3));
`endif

        // Saturation: 20 stalled step-cycles on a 4-bit counter.
        i_step  = 1'b1;
        i_flush = 1'b0;
        drive(1'b0, 16'h0000);
        for (int k = 0; k < 5; k++) tick();
`ifdef PIPE_STAGE_SKID_EN
        chk("sat_mid", 128'(o_stall_count), 128'(10));
`else
        chk("sat_mid", 128'(o_stall_count), 128'(8));
`endif
        for (int k = 0; k < 15; k++) tick();
        $display("saturation -> cnt=%0d", o_stall_count);
        chk("sat_cnt", 128'(o_stall_count), 128'(15));
        chk("sat_ctrl", 128'(o_ctrl), 128'(16'h00D4));

        // Asynchronous reset between edges while an entry is held.
        i_ready   = 1'b0;
        i_reset_n = 1'b0;
        #1;
        $display("async reset -> o_valid=%0b o_ctrl=%0h o_ready=%0b cnt=%0d", o_valid, o_ctrl, o_ready, o_stall_count);
        chk("arst_valid", 128'(o_valid), 128'(0));
        chk("arst_ctrl",  128'(o_ctrl),  128'(0));
        chk("arst_data",  128'(o_data),  128'(0));
        chk("arst_ready", 128'(o_ready), 128'(1));
        chk("arst_cnt",   128'(o_stall_count), 128'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
